// File: rtl/reg_file_param.sv
// Parametrised register file: one synchronous write port, two registered read
// ports with write-first bypass, single-cycle bulk clear and per-entry written flags.
module reg_file_param #(
    parameter int WIDTH  = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [WIDTH-1:0]  wr_data,
    input  logic              rd_en_a,
    input  logic [ADDR_W-1:0] rd_addr_a,
    output logic [WIDTH-1:0]  rd_data_a,
    output logic              rd_valid_a,
    input  logic              rd_en_b,
    input  logic [ADDR_W-1:0] rd_addr_b,
    output logic [WIDTH-1:0]  rd_data_b,
    output logic              rd_valid_b,
    output logic [DEPTH-1:0]  written
);

    // DEPTH may be any value up to 2^ADDR_W, so the bound needs one extra bit.
    localparam logic [ADDR_W:0] LP_DEPTH = DEPTH[ADDR_W:0];

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [DEPTH-1:0] r_written;
    logic [WIDTH-1:0] r_rd_data_a_p1;
    logic [WIDTH-1:0] r_rd_data_b_p1;
    logic             r_vld_a_p1;
    logic             r_vld_b_p1;

    logic             w_wr_hit;
    logic [WIDTH-1:0] w_rd_next_a;
    logic [WIDTH-1:0] w_rd_next_b;

    function automatic logic f_in_range(input logic [ADDR_W-1:0] addr);
        return ({1'b0, addr} < LP_DEPTH);
    endfunction

    // Clear wins over everything, then the bypassed write, then stored data.
    function automatic logic [WIDTH-1:0] f_rd_select(
        input logic [ADDR_W-1:0] addr,
        input logic              clr_now,
        input logic              wr_hit,
        input logic [ADDR_W-1:0] waddr,
        input logic [WIDTH-1:0]  wdata,
        input logic [WIDTH-1:0]  stored
    );
        if (clr_now || !f_in_range(addr)) begin
            return '0;
        end
        if (wr_hit && (waddr == addr)) begin
            return wdata;
        end
        return stored;
    endfunction

    assign w_wr_hit = wr_en && f_in_range(wr_addr);

    always_comb begin
        w_rd_next_a = '0;
        w_rd_next_b = '0;
        if (f_in_range(rd_addr_a)) begin
            w_rd_next_a = f_rd_select(rd_addr_a, clr, w_wr_hit, wr_addr, wr_data,
                                      r_mem[rd_addr_a]);
        end
        if (f_in_range(rd_addr_b)) begin
            w_rd_next_b = f_rd_select(rd_addr_b, clr, w_wr_hit, wr_addr, wr_data,
                                      r_mem[rd_addr_b]);
        end
    end

    // Storage and written flags
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_written <= '0;
        end else if (w_wr_hit) begin
            r_mem[wr_addr]     <= wr_data;
            r_written[wr_addr] <= 1'b1;
        end
    end

    // Read stage p1: data holds when the port is idle, valid tracks the request
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_data_a_p1 <= '0;
            r_rd_data_b_p1 <= '0;
            r_vld_a_p1     <= 1'b0;
            r_vld_b_p1     <= 1'b0;
        end else begin
            r_vld_a_p1 <= rd_en_a;
            r_vld_b_p1 <= rd_en_b;
            if (rd_en_a) begin
                r_rd_data_a_p1 <= w_rd_next_a;
            end
            if (rd_en_b) begin
                r_rd_data_b_p1 <= w_rd_next_b;
            end
        end
    end

    assign rd_data_a  = r_rd_data_a_p1;
    assign rd_valid_a = r_vld_a_p1;
    assign rd_data_b  = r_rd_data_b_p1;
    assign rd_valid_b = r_vld_b_p1;
    assign written    = r_written;

endmodule

// File: tb/tb_reg_file_param.sv
// Directed bench for reg_file_param: default 4x8, a 5-entry (non power of two)
// instance and a 32-bit-wide instance, sharing clock and reset.
module tb_reg_file_param;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Default instance: WIDTH=8, DEPTH=4, ADDR_W=2
    logic       d4_clr = 0, d4_wr_en = 0, d4_rd_en_a = 0, d4_rd_en_b = 0;
    logic [1:0] d4_wr_addr = 0, d4_rd_addr_a = 0, d4_rd_addr_b = 0;
    logic [7:0] d4_wr_data = 0, d4_rd_data_a, d4_rd_data_b;
    logic       d4_rd_valid_a, d4_rd_valid_b;
    logic [3:0] d4_written;

    reg_file_param #(.WIDTH(8), .DEPTH(4), .ADDR_W(2)) u_d4 (
        .clk(clk), .rst(rst), .clr(d4_clr),
        .wr_en(d4_wr_en), .wr_addr(d4_wr_addr), .wr_data(d4_wr_data),
        .rd_en_a(d4_rd_en_a), .rd_addr_a(d4_rd_addr_a),
        .rd_data_a(d4_rd_data_a), .rd_valid_a(d4_rd_valid_a),
        .rd_en_b(d4_rd_en_b), .rd_addr_b(d4_rd_addr_b),
        .rd_data_b(d4_rd_data_b), .rd_valid_b(d4_rd_valid_b),
        .written(d4_written)
    );

    // Non-power-of-two instance: DEPTH=5, ADDR_W=3
    logic       d5_clr = 0, d5_wr_en = 0, d5_rd_en_a = 0, d5_rd_en_b = 0;
    logic [2:0] d5_wr_addr = 0, d5_rd_addr_a = 0, d5_rd_addr_b = 0;
    logic [7:0] d5_wr_data = 0, d5_rd_data_a, d5_rd_data_b;
    logic       d5_rd_valid_a, d5_rd_valid_b;
    logic [4:0] d5_written;

    reg_file_param #(.WIDTH(8), .DEPTH(5), .ADDR_W(3)) u_d5 (
        .clk(clk), .rst(rst), .clr(d5_clr),
        .wr_en(d5_wr_en), .wr_addr(d5_wr_addr), .wr_data(d5_wr_data),
        .rd_en_a(d5_rd_en_a), .rd_addr_a(d5_rd_addr_a),
        .rd_data_a(d5_rd_data_a), .rd_valid_a(d5_rd_valid_a),
        .rd_en_b(d5_rd_en_b), .rd_addr_b(d5_rd_addr_b),
        .rd_data_b(d5_rd_data_b), .rd_valid_b(d5_rd_valid_b),
        .written(d5_written)
    );

    // Wide instance: WIDTH=32
    logic        dw_clr = 0, dw_wr_en = 0, dw_rd_en_a = 0, dw_rd_en_b = 0;
    logic [1:0]  dw_wr_addr = 0, dw_rd_addr_a = 0, dw_rd_addr_b = 0;
    logic [31:0] dw_wr_data = 0, dw_rd_data_a, dw_rd_data_b;
    logic        dw_rd_valid_a, dw_rd_valid_b;
    logic [3:0]  dw_written;

    reg_file_param #(.WIDTH(32), .DEPTH(4), .ADDR_W(2)) u_dw (
        .clk(clk), .rst(rst), .clr(dw_clr),
        .wr_en(dw_wr_en), .wr_addr(dw_wr_addr), .wr_data(dw_wr_data),
        .rd_en_a(dw_rd_en_a), .rd_addr_a(dw_rd_addr_a),
        .rd_data_a(dw_rd_data_a), .rd_valid_a(dw_rd_valid_a),
        .rd_en_b(dw_rd_en_b), .rd_addr_b(dw_rd_addr_b),
        .rd_data_b(dw_rd_data_b), .rd_valid_b(dw_rd_valid_b),
        .written(dw_written)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        logic [7:0] vals [4];
        vals = '{8'h11, 8'h22, 8'h33, 8'h44};

        // Reset with a write and reads pending: all discarded
        #1;
        rst = 1'b1;
        d4_wr_en = 1'b1; d4_wr_addr = 2'd1; d4_wr_data = 8'hAA;
        d4_rd_en_a = 1'b1; d4_rd_addr_a = 2'd1;
        step();
        step();
        chk("rst_data_a",  d4_rd_data_a,  8'h00);
        chk("rst_data_b",  d4_rd_data_b,  8'h00);
        chk("rst_valid_a", d4_rd_valid_a, 1'b0);
        chk("rst_valid_b", d4_rd_valid_b, 1'b0);
        chk("rst_written", d4_written,    4'b0000);
        chk("rst_written_d5", d5_written, 5'b00000);
        rst = 1'b0;
        d4_wr_en = 1'b0;
        step();
        chk("post_rst_rd1", d4_rd_data_a, 8'h00);
        chk("post_rst_vld", d4_rd_valid_a, 1'b1);
        chk("post_rst_written", d4_written, 4'b0000);
        d4_rd_en_a = 1'b0;

        // Fill all four entries
        for (int i = 0; i < 4; i++) begin
            d4_wr_en = 1'b1; d4_wr_addr = 2'(i); d4_wr_data = vals[i];
            step();
        end
        d4_wr_en = 1'b0;
        d4_rd_en_a = 1'b1; d4_rd_addr_a = 2'd2;
        d4_rd_en_b = 1'b1; d4_rd_addr_b = 2'd3;
        step();
        chk("basic_a",  d4_rd_data_a, 8'h33);
        chk("basic_b",  d4_rd_data_b, 8'h44);
        chk("basic_va", d4_rd_valid_a, 1'b1);
        chk("basic_vb", d4_rd_valid_b, 1'b1);
        chk("basic_written", d4_written, 4'b1111);

        // Write-first bypass on A while B reads an untouched entry
        d4_wr_en = 1'b1; d4_wr_addr = 2'd1; d4_wr_data = 8'h5A;
        d4_rd_addr_a = 2'd1; d4_rd_addr_b = 2'd0;
        step();
        chk("bypass_a", d4_rd_data_a, 8'h5A);
        chk("bypass_b", d4_rd_data_b, 8'h11);
        d4_wr_en = 1'b0;
        d4_rd_addr_b = 2'd1;
        step();
        chk("stored_after_bypass", d4_rd_data_a, 8'h5A);
        chk("same_addr_b", d4_rd_data_b, 8'h5A);

        // Hold: data sticks, valid drops
        d4_rd_addr_a = 2'd2; d4_rd_en_b = 1'b0;
        step();
        chk("hold_load", d4_rd_data_a, 8'h33);
        chk("hold_vb_low", d4_rd_valid_b, 1'b0);
        chk("hold_b_kept", d4_rd_data_b, 8'h5A);
        d4_rd_en_a = 1'b0;
        for (int i = 0; i < 3; i++) begin
            d4_rd_addr_a = 2'(i + 1);
            step();
            chk("hold_data", d4_rd_data_a, 8'h33);
            chk("hold_valid", d4_rd_valid_a, 1'b0);
        end

        // Clear colliding with a write and a read
        d4_clr = 1'b1;
        d4_wr_en = 1'b1; d4_wr_addr = 2'd0; d4_wr_data = 8'hFF;
        d4_rd_en_a = 1'b1; d4_rd_addr_a = 2'd0;
        step();
        chk("clr_rd", d4_rd_data_a, 8'h00);
        chk("clr_vld", d4_rd_valid_a, 1'b1);
        chk("clr_written", d4_written, 4'b0000);
        d4_clr = 1'b0; d4_wr_en = 1'b0;
        step();
        chk("clr_after_rd", d4_rd_data_a, 8'h00);
        d4_rd_addr_a = 2'd3;
        step();
        chk("clr_entry3", d4_rd_data_a, 8'h00);
        d4_rd_en_a = 1'b0;

        // Non-power-of-two depth: entry 4 works, address 6 is outside
        d5_wr_en = 1'b1; d5_wr_addr = 3'd4; d5_wr_data = 8'h9C;
        step();
        chk("d5_written4", d5_written, 5'b10000);
        d5_wr_addr = 3'd6; d5_wr_data = 8'h77;
        d5_rd_en_a = 1'b1; d5_rd_addr_a = 3'd4;
        step();
        chk("d5_oob_wr_written", d5_written, 5'b10000);
        chk("d5_rd4", d5_rd_data_a, 8'h9C);
        d5_wr_en = 1'b0;
        d5_rd_addr_a = 3'd6;
        d5_rd_en_b = 1'b1; d5_rd_addr_b = 3'd4;
        step();
        chk("d5_rd6", d5_rd_data_a, 8'h00);
        chk("d5_rd6_vld", d5_rd_valid_a, 1'b1);
        chk("d5_rd4_b", d5_rd_data_b, 8'h9C);
        // Out-of-range write must not bypass into an out-of-range read either
        d5_wr_en = 1'b1; d5_wr_addr = 3'd6; d5_wr_data = 8'h77;
        d5_rd_addr_b = 3'd6;
        step();
        chk("d5_oob_bypass", d5_rd_data_b, 8'h00);
        d5_wr_en = 1'b0; d5_rd_en_a = 1'b0; d5_rd_en_b = 1'b0;

        // Wide data round-trip and bypass
        dw_wr_en = 1'b1; dw_wr_addr = 2'd2; dw_wr_data = 32'hDEADBEEF;
        step();
        dw_wr_addr = 2'd3; dw_wr_data = 32'hCAFEF00D;
        dw_rd_en_a = 1'b1; dw_rd_addr_a = 2'd2;
        dw_rd_en_b = 1'b1; dw_rd_addr_b = 2'd3;
        step();
        chk("w32_rd", dw_rd_data_a, 32'hDEADBEEF);
        chk("w32_bypass", dw_rd_data_b, 32'hCAFEF00D);
        chk("w32_written", dw_written, 4'b1100);
        dw_wr_en = 1'b0;

        // Reset mid-operation zeroes outputs immediately
        rst = 1'b1;
        step();
        chk("midrst_data", dw_rd_data_a, 32'h0);
        chk("midrst_valid", dw_rd_valid_a, 1'b0);
        chk("midrst_written", dw_written, 4'b0000);
        rst = 1'b0;
        step();
        chk("midrst_rd_after", dw_rd_data_a, 32'h0);
        dw_rd_en_a = 1'b0; dw_rd_en_b = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
